// File: rtl/io_pwm_led_pkg.sv
// io_pwm_led_pkg: shared constants for the io_pwm_led block.
//   - io bus address and data widths
//   - register word offsets from BASE_ADR
//   - CTRL field layout and the packed CTRL register type
package io_pwm_led_pkg;

  localparam int unsigned IoAw  = 14;
  localparam int unsigned IoDw  = 32;
  localparam int unsigned NumCh = 4;

  // Register word offsets from BASE_ADR. The block decodes offsets 0..6.
  localparam logic [2:0] PWM_CTRL   = 3'd0;
  localparam logic [2:0] PWM_PERIOD = 3'd1;
  localparam logic [2:0] PWM_DUTY0  = 3'd2;
  localparam logic [2:0] PWM_STATUS = 3'd6;
  localparam logic [2:0] PwmLastOfs = 3'd6;

  // CTRL field bit positions.
  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned CtrlInvLsb   = 4;
  localparam int unsigned CtrlPreLsb   = 8;
  localparam int unsigned StatusEnBit  = 31;

  typedef struct packed {
    logic [7:0] pre;
    logic [3:0] inv;
    logic       irq_en;
    logic       en;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_word(input logic [IoDw-1:0] w);
    ctrl_t c;
    c.en     = w[CtrlEnBit];
    c.irq_en = w[CtrlIrqEnBit];
    c.inv    = w[CtrlInvLsb +: 4];
    c.pre    = w[CtrlPreLsb +: 8];
    return c;
  endfunction

  function automatic logic [IoDw-1:0] ctrl_to_word(input ctrl_t c);
    logic [IoDw-1:0] w;
    w                   = '0;
    w[CtrlEnBit]        = c.en;
    w[CtrlIrqEnBit]     = c.irq_en;
    w[CtrlInvLsb +: 4]  = c.inv;
    w[CtrlPreLsb +: 8]  = c.pre;
    return w;
  endfunction

endpackage

// File: rtl/io_pwm_led_channel.sv
// io_pwm_led_channel: one PWM output with a shadowed DUTY register.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_i           block enable (CTRL.EN)
//   copy_i         pending -> active copy strobe (period wrap or disabled)
//   wr_i, wdata_i  bus write to this channel's DUTY register
//   cnt_i          shared period counter
//   inv_i          output polarity inversion
//   duty_pend_o    pending DUTY value for register reads
//   pwm_o          registered PWM drive
module io_pwm_led_channel #(
  parameter int unsigned PW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          copy_i,
  input  logic          wr_i,
  input  logic [PW-1:0] wdata_i,
  input  logic [PW-1:0] cnt_i,
  input  logic          inv_i,
  output logic [PW-1:0] duty_pend_o,
  output logic          pwm_o
);

  logic [PW-1:0] duty_pend_q, duty_pend_d;
  logic [PW-1:0] duty_act_q, duty_act_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    duty_pend_d = wr_i ? wdata_i : duty_pend_q;
    // The active copy takes the old pending value, so a write landing on a
    // wrap applies one period later.
    duty_act_d  = copy_i ? duty_pend_q : duty_act_q;
    pwm_d       = en_i ? ((cnt_i < duty_act_q) ^ inv_i) : inv_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      pwm_q       <= 1'b0;
    end else begin
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      pwm_q       <= pwm_d;
    end
  end

  assign duty_pend_o = duty_pend_q;
  assign pwm_o       = pwm_q;

endmodule

// File: rtl/io_pwm_led.sv
// io_pwm_led: memory-mapped 4-channel PWM LED driver on the dma_io bus.
//   clk, rst                     clock, asynchronous active-high reset
//   dma_io_we/wadr/wdata         single-cycle register write
//   dma_io_radr/radr_en          single-cycle register read, data one cycle later
//   dma_io_rdata_in/rdata        read-data chain: pass-through unless our read hit
//   pwm_out                      PWM drive, one bit per LED
//   period_irq                   one-cycle pulse at each period wrap when IRQ_EN
// Holds the bus decode, prescaler, period counter and STATUS; the DUTY shadow and
// compare live in io_pwm_led_channel.
module io_pwm_led
  import io_pwm_led_pkg::*;
#(
  parameter logic [IoAw-1:0] BASE_ADR = 14'h3040,
  parameter int unsigned     PW       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dma_io_we,
  input  logic [IoAw-1:0] dma_io_wadr,
  input  logic [IoDw-1:0] dma_io_wdata,
  input  logic [IoAw-1:0] dma_io_radr,
  input  logic            dma_io_radr_en,
  input  logic [IoDw-1:0] dma_io_rdata_in,
  output logic [IoDw-1:0] dma_io_rdata,
  output logic [3:0]      pwm_out,
  output logic            period_irq
);

  ctrl_t           ctrl_q, ctrl_d;
  logic [PW-1:0]   period_pend_q, period_pend_d;
  logic [PW-1:0]   period_act_q, period_act_d;
  logic [7:0]      pre_cnt_q, pre_cnt_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [15:0]     status_q, status_d;
  logic            irq_q, irq_d;
  logic [IoDw-1:0] rdata_q, rdata_d;
  logic            rd_hit_q, rd_hit_d;

  logic [IoAw-1:0] wofs, rofs;
  logic            wr_hit;
  logic            wr_ctrl, wr_period, wr_status;
  logic [NumCh-1:0] wr_duty;
  logic            tick, wrap, copy;
  logic [PW-1:0]   duty_pend [NumCh];
  logic [NumCh-1:0] pwm;
  logic            unused_wdata;

  // Offsets below BASE_ADR wrap to large values, so one compare bounds both ends.
  assign wofs     = dma_io_wadr - BASE_ADR;
  assign rofs     = dma_io_radr - BASE_ADR;
  assign wr_hit   = dma_io_we && (wofs <= IoAw'(PwmLastOfs));
  assign rd_hit_d = dma_io_radr_en && (rofs <= IoAw'(PwmLastOfs));

  always_comb begin
    wr_ctrl   = wr_hit && (wofs[2:0] == PWM_CTRL);
    wr_period = wr_hit && (wofs[2:0] == PWM_PERIOD);
    wr_status = wr_hit && (wofs[2:0] == PWM_STATUS);
    for (int n = 0; n < NumCh; n++) begin
      wr_duty[n] = wr_hit && (wofs[2:0] == PWM_DUTY0 + 3'(n));
    end
  end

  assign tick = ctrl_q.en && (pre_cnt_q == ctrl_q.pre);
  assign wrap = tick && (cnt_q == period_act_q);
  // Shadow copies are transparent while disabled so the first period after
  // enabling uses whatever was last written.
  assign copy = wrap || !ctrl_q.en;

  always_comb begin
    ctrl_d        = wr_ctrl ? ctrl_from_word(dma_io_wdata) : ctrl_q;
    period_pend_d = wr_period ? dma_io_wdata[PW-1:0] : period_pend_q;
    period_act_d  = copy ? period_pend_q : period_act_q;

    if (!ctrl_q.en || tick) pre_cnt_d = '0;
    else                    pre_cnt_d = pre_cnt_q + 8'd1;

    if (!ctrl_q.en || wrap) cnt_d = '0;
    else if (tick)          cnt_d = cnt_q + PW'(1);
    else                    cnt_d = cnt_q;

    // A clearing write beats a coincident wrap.
    if (wr_status) status_d = '0;
    else if (wrap) status_d = status_q + 16'd1;
    else           status_d = status_q;

    irq_d = wrap && ctrl_q.irq_en;
  end

  always_comb begin
    rdata_d = '0;
    case (rofs[2:0])
      PWM_CTRL:          rdata_d = ctrl_to_word(ctrl_q);
      PWM_PERIOD:        rdata_d = IoDw'(period_pend_q);
      PWM_DUTY0:         rdata_d = IoDw'(duty_pend[0]);
      PWM_DUTY0 + 3'd1:  rdata_d = IoDw'(duty_pend[1]);
      PWM_DUTY0 + 3'd2:  rdata_d = IoDw'(duty_pend[2]);
      PWM_DUTY0 + 3'd3:  rdata_d = IoDw'(duty_pend[3]);
      PWM_STATUS: begin
        rdata_d[15:0]        = status_q;
        rdata_d[StatusEnBit] = ctrl_q.en;
      end
      default:           rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q        <= '0;
      period_pend_q <= '0;
      period_act_q  <= '0;
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      status_q      <= '0;
      irq_q         <= 1'b0;
      rdata_q       <= '0;
      rd_hit_q      <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      period_pend_q <= period_pend_d;
      period_act_q  <= period_act_d;
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      status_q      <= status_d;
      irq_q         <= irq_d;
      rdata_q       <= rdata_d;
      rd_hit_q      <= rd_hit_d;
    end
  end

  for (genvar n = 0; n < NumCh; n++) begin : g_ch
    io_pwm_led_channel #(
      .PW (PW)
    ) u_channel (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (ctrl_q.en),
      .copy_i      (copy),
      .wr_i        (wr_duty[n]),
      .wdata_i     (dma_io_wdata[PW-1:0]),
      .cnt_i       (cnt_q),
      .inv_i       (ctrl_q.inv[n]),
      .duty_pend_o (duty_pend[n]),
      .pwm_o       (pwm[n])
    );
  end

  assign dma_io_rdata = rd_hit_q ? rdata_q : dma_io_rdata_in;
  assign pwm_out      = pwm;
  assign period_irq   = irq_q;

  assign unused_wdata = ^{dma_io_wdata[31:16], dma_io_wdata[3:2]};

endmodule

// File: tb/tb_io_pwm_led.sv
module tb_io_pwm_led;

  localparam logic [13:0] BASE = 14'h3040;

  logic        clk;
  logic        rst;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;
  logic [3:0]  pwm_out;
  logic        period_irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queues: expectations are pushed when stimulus is driven and
  // popped when the DUT presents the corresponding output.
  logic [31:0] rd_exp_q  [$];
  logic [3:0]  pwm_exp_q [$];
  logic        irq_exp_q [$];

  io_pwm_led u_dut (
    .clk             (clk),
    .rst             (rst),
    .dma_io_we       (dma_io_we),
    .dma_io_wadr     (dma_io_wadr),
    .dma_io_wdata    (dma_io_wdata),
    .dma_io_radr     (dma_io_radr),
    .dma_io_radr_en  (dma_io_radr_en),
    .dma_io_rdata_in (dma_io_rdata_in),
    .dma_io_rdata    (dma_io_rdata),
    .pwm_out         (pwm_out),
    .period_irq      (period_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [13:0] adr, input logic [31:0] data);
    dma_io_we    = 1'b1;
    dma_io_wadr  = adr;
    dma_io_wdata = data;
    tick();
    dma_io_we    = 1'b0;
  endtask

  task automatic rd(input logic [13:0] adr, input logic [31:0] exp, input string tag);
    dma_io_radr_en = 1'b1;
    dma_io_radr    = adr;
    rd_exp_q.push_back(exp);
    tick();
    dma_io_radr_en = 1'b0;
    chk(tag, dma_io_rdata, rd_exp_q.pop_front());
  endtask

  task automatic step_pwm(input logic [3:0] pwm_exp, input logic irq_exp, input string tag);
    pwm_exp_q.push_back(pwm_exp);
    irq_exp_q.push_back(irq_exp);
    tick();
    chk({tag, "_pwm"}, 32'(pwm_out), 32'(pwm_exp_q.pop_front()));
    chk({tag, "_irq"}, 32'(period_irq), 32'(irq_exp_q.pop_front()));
  endtask

  task automatic step_irq(input logic irq_exp, input string tag);
    irq_exp_q.push_back(irq_exp);
    tick();
    chk(tag, 32'(period_irq), 32'(irq_exp_q.pop_front()));
  endtask

  // Expected PWM vector for counter value c.
  function automatic logic [3:0] pwm_model(input int c, input int d0, input int d1,
                                           input int d2, input int d3, input logic [3:0] inv);
    logic [3:0] v;
    v[0] = (c < d0);
    v[1] = (c < d1);
    v[2] = (c < d2);
    v[3] = (c < d3);
    return v ^ inv;
  endfunction

  initial begin
    rst             = 1'b1;
    dma_io_we       = 1'b0;
    dma_io_wadr     = '0;
    dma_io_wdata    = '0;
    dma_io_radr     = '0;
    dma_io_radr_en  = 1'b0;
    dma_io_rdata_in = 32'hA5A5_A5A5;

    // Reset state, before and across a clock edge.
    #3;
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_irq", 32'(period_irq), 32'h0);
    chk("rst_chain", dma_io_rdata, 32'hA5A5_A5A5);
    tick();
    chk("rst_edge_pwm", 32'(pwm_out), 32'h0);
    rst = 1'b0;
    tick();
    rd(BASE + 14'd0, 32'h0, "rst_ctrl_rd");

    // Basic PWM: PERIOD=9, DUTY={3,0,10,5}, PRE=0.
    wr(BASE + 14'd1, 32'd9);
    wr(BASE + 14'd2, 32'd3);
    wr(BASE + 14'd3, 32'd0);
    wr(BASE + 14'd4, 32'd10);
    wr(BASE + 14'd5, 32'd5);
    rd(BASE + 14'd1, 32'd9, "period_rd");
    rd(BASE + 14'd5, 32'd5, "duty3_rd");
    wr(BASE + 14'd0, 32'h0000_0001);
    for (int j = 1; j <= 20; j++) begin
      step_pwm(pwm_model((j - 1) % 10, 3, 0, 10, 5, 4'b0000), 1'b0, "basic");
    end

    // Prescale and IRQ: PRE=3, PERIOD=4 -> 20 clocks per period.
    wr(BASE + 14'd0, 32'h0);
    wr(BASE + 14'd1, 32'd4);
    wr(BASE + 14'd6, 32'h0);
    wr(BASE + 14'd0, 32'h0000_0303);
    for (int m = 1; m <= 100; m++) begin
      step_irq((m % 20) == 0, "presc_irq");
    end
    rd(BASE + 14'd6, 32'h8000_0005, "status_count");
    wr(BASE + 14'd6, 32'h1234_5678);
    rd(BASE + 14'd6, 32'h8000_0000, "status_clear");

    // Shadow update: DUTY0 2 -> 8 written mid-period.
    wr(BASE + 14'd0, 32'h0);
    wr(BASE + 14'd1, 32'd9);
    wr(BASE + 14'd2, 32'd2);
    wr(BASE + 14'd0, 32'h0000_0001);
    for (int j = 1; j <= 4; j++) begin
      step_pwm(pwm_model(j - 1, 2, 0, 10, 5, 4'b0000), 1'b0, "shadow_a");
    end
    dma_io_we    = 1'b1;
    dma_io_wadr  = BASE + 14'd2;
    dma_io_wdata = 32'd8;
    step_pwm(pwm_model(4, 2, 0, 10, 5, 4'b0000), 1'b0, "shadow_wr");
    dma_io_we      = 1'b0;
    dma_io_radr_en = 1'b1;
    dma_io_radr    = BASE + 14'd2;
    rd_exp_q.push_back(32'd8);
    step_pwm(pwm_model(5, 2, 0, 10, 5, 4'b0000), 1'b0, "shadow_rd");
    dma_io_radr_en = 1'b0;
    chk("shadow_duty0_rd", dma_io_rdata, rd_exp_q.pop_front());
    for (int j = 7; j <= 20; j++) begin
      step_pwm(pwm_model((j - 1) % 10, (j <= 10) ? 2 : 8, 0, 10, 5, 4'b0000), 1'b0,
               "shadow_b");
    end

    // Disable and invert.
    wr(BASE + 14'd0, 32'h0000_00A3);
    tick();
    tick();
    tick();
    wr(BASE + 14'd0, 32'h0000_00A2);
    for (int j = 1; j <= 25; j++) begin
      step_pwm(4'b1010, 1'b0, "disabled");
    end
    wr(BASE + 14'd0, 32'h0000_0003);
    for (int j = 1; j <= 10; j++) begin
      step_pwm(pwm_model(j - 1, 8, 0, 10, 5, 4'b0000), j == 10, "reenable");
    end

    // Decode and chain.
    wr(BASE + 14'd7, 32'h0);
    wr(BASE - 14'd1, 32'h0);
    rd(BASE + 14'd0, 32'h0000_0003, "dec_ctrl");
    rd(BASE + 14'd1, 32'd9, "dec_period");
    rd(BASE + 14'd2, 32'd8, "dec_duty0");
    rd(BASE + 14'd4, 32'd10, "dec_duty2");
    rd(BASE + 14'd5, 32'd5, "dec_duty3");
    dma_io_rdata_in = 32'h1234_5678;
    rd(BASE + 14'd7, 32'h1234_5678, "chain_above");
    rd(BASE - 14'd1, 32'h1234_5678, "chain_below");
    tick();
    dma_io_rdata_in = 32'hDEAD_BEEF;
    #1;
    chk("chain_comb", dma_io_rdata, 32'hDEAD_BEEF);

    // Asynchronous reset mid-period.
    chk("pre_rst_pwm2", 32'(pwm_out[2]), 32'h1);
    rst = 1'b1;
    #2;
    chk("async_rst_pwm", 32'(pwm_out), 32'h0);
    chk("async_rst_irq", 32'(period_irq), 32'h0);
    chk("async_rst_chain", dma_io_rdata, 32'hDEAD_BEEF);
    tick();
    rst = 1'b0;
    rd(BASE + 14'd0, 32'h0, "post_rst_ctrl");
    rd(BASE + 14'd1, 32'h0, "post_rst_period");
    rd(BASE + 14'd6, 32'h0, "post_rst_status");
    step_pwm(4'b0000, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
